mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data share one memory port.
// Data normally wins; fetch is guaranteed a slot after STARVE_MAX data grants
// that happened while fetch was waiting. Only one read can be outstanding.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_cs,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;         // remaining WAIT cycles after the current one
  logic        owner_d;     // 1: outstanding read belongs to the data port
  logic [3:0]  starve_cnt;
  logic        if_win, d_win, rd_start, rd_done, hungry;

  // Arbitration and memory-port drive; grants forced low while in reset
  always_comb begin
    if_win    = 1'b0;
    d_win     = 1'b0;
    state_nxt = state;
    hungry    = (starve_cnt == 4'(STARVE_MAX));
    if (rst_n && state == IDLE) begin
      if_win = if_req && (!d_req || hungry);
      d_win  = d_req && !if_win;
    end
    rd_start = if_win || (d_win && !d_we);
    rd_done  = (state == WAIT) && (cnt == 3'd0);
    if_gnt   = if_win;
    d_gnt    = d_win;
    m_cs     = if_win || d_win;
    m_we     = d_win && d_we;
    m_addr   = if_win ? if_addr : (d_win ? d_addr : '0);
    m_wdata  = d_win ? d_wdata : '0;
    case (state)
      IDLE:    if (rd_start) state_nxt = WAIT;
      WAIT:    if (rd_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read tracking: latency counter, owner, capture and one-cycle rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 3'd0;
      owner_d   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (rd_start) begin
        cnt     <= 3'(LAT - 1);
        owner_d <= d_win;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (rd_done) begin
        if (owner_d) begin
          d_rdata  <= m_rdata;
          d_rvalid <= 1'b1;
        end else begin
          if_rdata  <= m_rdata;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

  // Starvation counter: counts data grants taken while fetch was waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= 4'd0;
    else if (if_win)
      starve_cnt <= 4'd0;
    else if (d_win && if_req && !hungry)
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule
